mem_arbiter: RTL and testbench

Two-requester access controller for the shared byte-addressed data memory (`memory`, 512 bytes, big-endian word view) in the mips2riscv core. It arbitrates between the instruction-fetch port (read-only) and the load/store port (read/write), sequences each access through a fixed three-state machine, and validates alignment and range before any memory access. Responses are returned with registered data and an error flag.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, owner IDs,
// and helpers for the starvation counter width and the address-validity rule.
package mem_pkg;

    localparam int unsigned MEM_BYTES_DFLT    = 512;
    localparam int unsigned STARVE_LIMIT_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    function automatic int unsigned streak_width(input int unsigned limit);
        return ($clog2(limit + 1) > 3) ? $clog2(limit + 1) : 3;
    endfunction

    // Word access must be aligned and end inside the memory; unsigned over all 32 bits.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: load/store by default, fetch when it is the
// only requester or when load/store has used up its starvation allowance.
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT,
    parameter int unsigned SW           = streak_width(STARVE_LIMIT)
) (
    input  logic          if_req_i,
    input  logic          ls_req_i,
    input  logic [SW-1:0] ls_streak_i,
    output owner_t        winner_o,
    output logic          grant_valid_o
);

    always_comb begin
        grant_valid_o = if_req_i | ls_req_i;
        winner_o      = OWN_LS;
        if (if_req_i && (!ls_req_i || (ls_streak_i == SW'(STARVE_LIMIT)))) begin
            winner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) access controller for the shared data memory.
// Each access runs IDLE -> ACCESS -> RESP with registered response data.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = MEM_BYTES_DFLT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut,
    output logic        busy
);

    localparam int unsigned SW = streak_width(STARVE_LIMIT);

    state_t        state_q,  state_d;
    owner_t        owner_q,  owner_d;
    logic          op_we_q,  op_we_d;
    logic [31:0]   addr_q,   addr_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic          err_q,    err_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic [SW-1:0] streak_q, streak_d;

    owner_t        winner;
    logic          grant_valid;
    logic [31:0]   sel_addr;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .if_req_i      (if_req),
        .ls_req_i      (ls_req),
        .ls_streak_i   (streak_q),
        .winner_o      (winner),
        .grant_valid_o (grant_valid)
    );

    assign sel_addr = (winner == OWN_LS) ? ls_addr : if_addr;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        op_we_d  = op_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        streak_d = streak_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = winner;
                    op_we_d = (winner == OWN_LS) ? ls_we : 1'b0;
                    addr_d  = sel_addr;
                    wdata_d = (winner == OWN_LS) ? ls_wdata : '0;
                    err_d   = addr_err(sel_addr, MEM_BYTES);
                    state_d = ACCESS;
                    // Streak counts only LS wins that made a waiting fetch wait longer.
                    if (!if_req || (winner == OWN_IF)) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(STARVE_LIMIT)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            ACCESS: begin
                rdata_d = (!op_we_q && !err_q) ? mem_dataOut : '0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            op_we_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_we_q  <= op_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            streak_q <= streak_d;
        end
    end

    assign if_ack    = (state_q == ACCESS) && (owner_q == OWN_IF);
    assign ls_ack    = (state_q == ACCESS) && (owner_q == OWN_LS);
    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign ls_rdata  = ls_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid & err_q;
    assign ls_err    = ls_rvalid & err_q;

    // Write strobe is cut by RST directly so a reset in ACCESS never commits.
    assign mem_read   = (state_q == ACCESS) && !op_we_q && !err_q;
    assign mem_write  = (state_q == ACCESS) && op_we_q && !err_q && !RST;
    assign mem_addr   = addr_q;
    assign mem_dataIn = wdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 512-byte big-endian memory model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ack, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_dataIn, mem_dataOut;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rd_strobes = 0;
    int wr_strobes = 0;

    logic [7:0]  mem [0:511];
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .MEM_BYTES    (512),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .if_err      (if_err),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_ack      (ls_ack),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .ls_err      (ls_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut),
        .busy        (busy)
    );

    always_comb begin
        mem_dataOut = '0;
        if (mem_addr <= 32'd508) begin
            mem_dataOut = {mem[mem_addr[8:0]], mem[mem_addr[8:0] + 9'd1],
                           mem[mem_addr[8:0] + 9'd2], mem[mem_addr[8:0] + 9'd3]};
        end
    end

    always @(posedge CLK) begin
        if (bd_we) begin
            mem[bd_addr[8:0]]         <= bd_data[31:24];
            mem[bd_addr[8:0] + 9'd1]  <= bd_data[23:16];
            mem[bd_addr[8:0] + 9'd2]  <= bd_data[15:8];
            mem[bd_addr[8:0] + 9'd3]  <= bd_data[7:0];
        end else if (mem_write && mem_addr <= 32'd508) begin
            mem[mem_addr[8:0]]        <= mem_dataIn[31:24];
            mem[mem_addr[8:0] + 9'd1] <= mem_dataIn[23:16];
            mem[mem_addr[8:0] + 9'd2] <= mem_dataIn[15:8];
            mem[mem_addr[8:0] + 9'd3] <= mem_dataIn[7:0];
        end
    end

    always @(negedge CLK) begin
        if (mem_read)  rd_strobes++;
        if (mem_write) wr_strobes++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge CLK);
        bd_we   = 1'b0;
    endtask

    // Runs one LS access from an IDLE negedge; returns at the next IDLE negedge.
    task automatic ls_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output logic ok);
        int n;
        ok = 1'b1;
        rd = '0;
        er = 1'b0;
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        n = 0;
        @(negedge CLK);
        while (!ls_ack && n < 20) begin @(negedge CLK); n++; end
        if (!ls_ack) ok = 1'b0;
        ls_req = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!ls_rvalid && n < 20) begin @(negedge CLK); n++; end
        if (!ls_rvalid) ok = 1'b0;
        rd = ls_rdata;
        er = ls_err;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        RST = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge CLK);
        outs = {if_ack, if_rvalid, if_rdata, if_err, ls_ack, ls_rvalid, ls_rdata, ls_err,
                mem_read, mem_write, mem_addr, mem_dataIn, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_if_read();
        set_word(32'h10, 32'h11223344);
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge CLK);
        checks++;
        if ({if_ack, ls_ack, mem_read, mem_write, busy, if_rvalid} !== 6'b101010) begin
            errors++;
            $display("FAIL if_read_access: got ack/lsack/rd/wr/busy/rv=%b expected 101010",
                     {if_ack, ls_ack, mem_read, mem_write, busy, if_rvalid});
        end
        checks++;
        if (mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL if_read_mem_addr: got %h expected 00000010", mem_addr);
        end
        if_req = 1'b0;
        @(negedge CLK);
        checks++;
        if ({if_rvalid, if_err, if_ack, mem_read} !== 4'b1000) begin
            errors++;
            $display("FAIL if_read_resp_flags: got rv/err/ack/rd=%b expected 1000",
                     {if_rvalid, if_err, if_ack, mem_read});
        end
        checks++;
        if (if_rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL if_read_data: got %h expected 11223344", if_rdata);
        end
        @(negedge CLK);
        checks++;
        if ({busy, if_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL if_read_back_idle: got busy/rv=%b expected 00", {busy, if_rvalid});
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        logic er, ok;
        set_word(32'h00, 32'h01020304);
        set_word(32'h20, 32'h00000000);
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hDEADBEEF;
        @(negedge CLK);
        checks++;
        if ({ls_ack, if_ack, mem_write, mem_read} !== 4'b1010) begin
            errors++;
            $display("FAIL sim_ls_first: got lsack/ifack/wr/rd=%b expected 1010",
                     {ls_ack, if_ack, mem_write, mem_read});
        end
        ls_req = 1'b0;
        @(negedge CLK);
        checks++;
        if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL sim_ls_wr_resp: got rv=%b err=%b data=%h expected 1 0 0",
                     ls_rvalid, ls_err, ls_rdata);
        end
        @(negedge CLK);
        checks++;
        if ({if_ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL sim_t3_idle: got ifack/busy=%b expected 00", {if_ack, busy});
        end
        @(negedge CLK);
        checks++;
        if (if_ack !== 1'b1) begin
            errors++;
            $display("FAIL sim_if_ack_t4: got %b expected 1", if_ack);
        end
        if_req = 1'b0;
        @(negedge CLK);
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h01020304}) begin
            errors++;
            $display("FAIL sim_if_resp: got rv=%b data=%h expected 1 01020304", if_rvalid, if_rdata);
        end
        @(negedge CLK);
        ls_access(1'b0, 32'h20, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sim_readback: got ok=%b err=%b data=%h expected 1 0 deadbeef", ok, er, rd);
        end
    endtask

    task automatic test_starvation();
        logic [5:0] seq;
        int g, n;
        seq = '0;
        g = 0;
        n = 0;
        if_req = 1'b1; if_addr = 32'h4;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8; ls_wdata = '0;
        while (g < 6 && n < 60) begin
            @(negedge CLK);
            n++;
            if (if_ack) begin seq[g] = 1'b1; g++; end
            else if (ls_ack) begin seq[g] = 1'b0; g++; end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        checks++;
        if (g !== 6) begin
            errors++;
            $display("FAIL starve_grant_count: got %0d expected 6", g);
        end
        checks++;
        if (seq !== 6'b010000) begin
            errors++;
            $display("FAIL starve_order: got %b (bit0 first, 1=IF) expected 010000", seq);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_end_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er, ok;
        int rs, ws;
        set_word(32'h24, 32'h24242424);
        rs = rd_strobes;
        ws = wr_strobes;
        ls_access(1'b1, 32'h22, 32'h12345678, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_misaligned_wr: got ok=%b err=%b data=%h expected 1 1 0", ok, er, rd);
        end
        ls_access(1'b0, 32'h1FE, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_range_1fe: got ok=%b err=%b data=%h expected 1 1 0", ok, er, rd);
        end
        ls_access(1'b0, 32'h200, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_range_200: got ok=%b err=%b data=%h expected 1 1 0", ok, er, rd);
        end
        ls_access(1'b0, 32'hFFFFFFFC, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL err_range_top: got ok=%b err=%b data=%h expected 1 1 0", ok, er, rd);
        end
        checks++;
        if ({rd_strobes - rs, wr_strobes - ws} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL err_no_strobes: got reads=%0d writes=%0d expected 0 0",
                     rd_strobes - rs, wr_strobes - ws);
        end
        set_word(32'h1FC, 32'hCAFEF00D);
        ls_access(1'b0, 32'h1FC, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b10, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL err_last_word_ok: got ok=%b err=%b data=%h expected 1 0 cafef00d", ok, er, rd);
        end
        ls_access(1'b0, 32'h20, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL err_mem_unchanged_20: got ok=%b err=%b data=%h expected 1 0 deadbeef", ok, er, rd);
        end
        ls_access(1'b0, 32'h24, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b10, 32'h24242424}) begin
            errors++;
            $display("FAIL err_mem_unchanged_24: got ok=%b err=%b data=%h expected 1 0 24242424", ok, er, rd);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [136:0] outs;
        logic [31:0] rd;
        logic er, ok;
        int ws;
        set_word(32'h30, 32'h0BADF00D);
        ws = wr_strobes;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30; ls_wdata = 32'h55555555;
        @(negedge CLK);
        checks++;
        if (ls_ack !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_access: got ls_ack=%b expected 1", ls_ack);
        end
        RST = 1'b1;
        ls_req = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_write_gated: got mem_write=%b expected 0", mem_write);
        end
        @(negedge CLK);
        outs = {if_ack, if_rvalid, if_rdata, if_err, ls_ack, ls_rvalid, ls_rdata, ls_err,
                mem_read, mem_write, mem_addr, mem_dataIn, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h expected 0", outs);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, ls_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle: got busy/rv=%b expected 00", {busy, ls_rvalid});
        end
        ls_access(1'b0, 32'h30, 32'h0, rd, er, ok);
        checks++;
        if ({ok, er, rd} !== {2'b10, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL rstmid_mem_unchanged: got ok=%b err=%b data=%h expected 1 0 0badf00d", ok, er, rd);
        end
        checks++;
        if (wr_strobes !== ws) begin
            errors++;
            $display("FAIL rstmid_no_write: got %0d writes expected %0d", wr_strobes, ws);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        int k;
        addrs = '{32'h00, 32'h04, 32'h08};
        words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        for (int i = 0; i < 3; i++) set_word(addrs[i], words[i]);
        if_req = 1'b1; if_addr = addrs[0];
        for (int c = 0; c < 10; c++) begin
            k = c / 3;
            checks++;
            if (busy !== (c % 3 != 0)) begin
                errors++;
                $display("FAIL b2b_busy_c%0d: got %b expected %b", c, busy, (c % 3 != 0));
            end
            if (c % 3 == 1) begin
                checks++;
                if (if_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ack_c%0d: got %b expected 1", c, if_ack);
                end
                if (k < 2) if_addr = addrs[k + 1];
                else       if_req  = 1'b0;
            end else if (c % 3 == 2) begin
                checks++;
                if ({if_rvalid, if_err, if_rdata} !== {2'b10, words[k]}) begin
                    errors++;
                    $display("FAIL b2b_resp_c%0d: got rv=%b err=%b data=%h expected 1 0 %h",
                             c, if_rvalid, if_err, if_rdata, words[k]);
                end
            end else begin
                checks++;
                if (if_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_no_rvalid_c%0d: got %b expected 0", c, if_rvalid);
                end
            end
            @(negedge CLK);
        end
        if_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_simultaneous();
        test_starvation();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
